// File: rtl/cmd_pkg.sv
// Shared /CMD file-format constants and the save/load sequencing states.
package cmd_pkg;

    typedef enum logic [3:0] {
        IDLE,
        REC_TYPE,
        REC_LEN,
        REC_ALO,
        REC_AHI,
        MEM_REQ,
        DATA,
        XFR_TYPE,
        XFR_LEN,
        XFR_ALO,
        XFR_AHI,
        FIN
    } state_t;

    localparam logic [7:0] CMD_LOAD = 8'h01;
    localparam logic [7:0] CMD_XFER = 8'h02;
    localparam logic [7:0] XFER_LEN = 8'h02;

endpackage

// File: rtl/cmd_saver.sv
// Streams a RAM range out as a /CMD file: load records of up to BLOCK_MAX
// data bytes each, followed by a transfer record holding the entry address.
module cmd_saver
    import cmd_pkg::*;
#(
    parameter int unsigned BLOCK_MAX = 256
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] start_addr,
    input  logic [15:0] end_addr,
    input  logic [15:0] exec_addr,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_data,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    state_t      state;
    logic [16:0] cur;
    logic [16:0] end_ext;
    logic [15:0] exec_r;
    logic [8:0]  blk_cnt;
    logic [16:0] remaining;
    logic [8:0]  n_blk;
    logic [8:0]  len_sum;
    logic        accept;

    // 17-bit arithmetic lets a range ending at 0xFFFF finish without wrapping.
    assign remaining = end_ext - cur + 17'd1;
    assign accept    = out_valid & out_ready;
    assign len_sum   = n_blk + 9'd2;

    always_comb begin
        n_blk = remaining[8:0];
        if (remaining > 17'(BLOCK_MAX))
            n_blk = 9'(BLOCK_MAX);
    end

    // out_data doubles as the holding register for the byte read from RAM.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cur       <= '0;
            end_ext   <= '0;
            exec_r    <= '0;
            blk_cnt   <= '0;
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        cur       <= {1'b0, start_addr};
                        end_ext   <= {1'b0, end_addr};
                        exec_r    <= exec_addr;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                        if (end_addr >= start_addr) begin
                            state    <= REC_TYPE;
                            out_data <= CMD_LOAD;
                        end else begin
                            state    <= XFR_TYPE;
                            out_data <= CMD_XFER;
                        end
                    end
                end
                REC_TYPE: if (accept) begin
                    state    <= REC_LEN;
                    out_data <= len_sum[7:0];
                    blk_cnt  <= n_blk;
                end
                REC_LEN: if (accept) begin
                    state    <= REC_ALO;
                    out_data <= cur[7:0];
                end
                REC_ALO: if (accept) begin
                    state    <= REC_AHI;
                    out_data <= cur[15:8];
                end
                REC_AHI: if (accept) begin
                    state     <= MEM_REQ;
                    out_valid <= 1'b0;
                    mem_rd    <= 1'b1;
                    mem_addr  <= cur[15:0];
                end
                MEM_REQ: if (mem_ack) begin
                    state     <= DATA;
                    mem_rd    <= 1'b0;
                    out_data  <= mem_data;
                    out_valid <= 1'b1;
                end
                DATA: if (accept) begin
                    cur     <= cur + 17'd1;
                    blk_cnt <= blk_cnt - 9'd1;
                    if (blk_cnt == 9'd1) begin
                        if (remaining > 17'd1) begin
                            state    <= REC_TYPE;
                            out_data <= CMD_LOAD;
                        end else begin
                            state    <= XFR_TYPE;
                            out_data <= CMD_XFER;
                        end
                    end else begin
                        state     <= MEM_REQ;
                        out_valid <= 1'b0;
                        mem_rd    <= 1'b1;
                        mem_addr  <= cur[15:0] + 16'd1;
                    end
                end
                XFR_TYPE: if (accept) begin
                    state    <= XFR_LEN;
                    out_data <= XFER_LEN;
                end
                XFR_LEN: if (accept) begin
                    state    <= XFR_ALO;
                    out_data <= exec_r[7:0];
                end
                XFR_ALO: if (accept) begin
                    state    <= XFR_AHI;
                    out_data <= exec_r[15:8];
                    out_last <= 1'b1;
                end
                XFR_AHI: if (accept) begin
                    state     <= FIN;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
                FIN: begin
                    state <= IDLE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_saver.sv
// Scoreboard bench for cmd_saver: a reference model builds the expected /CMD
// stream and read-address sequence; monitors pop and compare as the DUT emits.
module tb_cmd_saver;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        start   = 1'b0;
    logic [15:0] start_addr = '0;
    logic [15:0] end_addr   = '0;
    logic [15:0] exec_addr  = '0;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic        mem_ack  = 1'b0;
    logic [7:0]  mem_data = '0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_last;
    logic        busy;
    logic        done;

    cmd_saver #(.BLOCK_MAX(256)) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .start     (start),
        .start_addr(start_addr),
        .end_addr  (end_addr),
        .exec_addr (exec_addr),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_data  (mem_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #12 clk_sys = ~clk_sys;

    logic [7:0] ram [0:65535];
    logic [8:0] exp_q[$];
    int         rd_q[$];
    int         passes = 0;
    int         checks = 0;
    int         done_cnt = 0;
    int         acc_cnt  = 0;
    int         ov_cnt   = 0;
    bit         stall_en = 1'b0;

    task automatic chk(input string name, input bit ok, input longint act, input longint exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference model: the file layout computed directly from address arithmetic.
    task automatic build(input int s, input int e, input int x);
        int cur, n;
        if (e >= s) begin
            cur = s;
            while (cur <= e) begin
                n = (e - cur + 1 > 256) ? 256 : e - cur + 1;
                exp_q.push_back({1'b0, 8'h01});
                exp_q.push_back({1'b0, 8'((n + 2) % 256)});
                exp_q.push_back({1'b0, 8'(cur % 256)});
                exp_q.push_back({1'b0, 8'(cur / 256)});
                for (int i = 0; i < n; i++) begin
                    exp_q.push_back({1'b0, ram[cur + i]});
                    rd_q.push_back(cur + i);
                end
                cur += n;
            end
        end
        exp_q.push_back({1'b0, 8'h02});
        exp_q.push_back({1'b0, 8'h02});
        exp_q.push_back({1'b0, 8'(x % 256)});
        exp_q.push_back({1'b1, 8'(x / 256)});
    endtask

    // Output monitor: a byte is accepted on the next rising edge.
    always @(negedge clk_sys) begin
        logic [8:0] e;
        if (!reset) begin
            if (out_valid && out_ready) begin
                acc_cnt++;
                if (exp_q.size() == 0) begin
                    chk("extra_byte", 1'b0, {out_last, out_data}, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("stream_byte", {out_last, out_data} == e, {out_last, out_data}, e);
                end
            end
            if (done) done_cnt++;
            if (mem_rd && out_valid) ov_cnt++;
        end
    end

    always @(posedge clk_sys) begin
        #1 out_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // RAM responder with a 0-5 cycle acknowledge latency under stall mode.
    initial begin
        int lat, a, ea;
        forever begin
            @(negedge clk_sys);
            if (mem_rd && !reset) begin
                lat = stall_en ? int'($urandom_range(0, 5)) : 0;
                a = int'(mem_addr);
                repeat (lat) @(negedge clk_sys);
                chk("mem_addr_stable", mem_rd && int'(mem_addr) == a, int'(mem_addr), a);
                if (rd_q.size() == 0) begin
                    chk("unexpected_read", 1'b0, a, 0);
                end else begin
                    ea = rd_q.pop_front();
                    chk("read_addr", a == ea, a, ea);
                end
                mem_data = ram[a];
                mem_ack  = 1'b1;
                @(posedge clk_sys);
                #1 mem_ack = 1'b0;
            end
        end
    end

    task automatic run_save(input int s, input int e, input int x, input bit glitch);
        int d0, ov0, cyc;
        build(s, e, x);
        d0  = done_cnt;
        ov0 = ov_cnt;
        @(posedge clk_sys);
        #1;
        start = 1'b1;
        start_addr = 16'(s);
        end_addr   = 16'(e);
        exec_addr  = 16'(x);
        @(posedge clk_sys);
        #1;
        start = 1'b0;
        start_addr = 16'($urandom);
        end_addr   = 16'($urandom);
        exec_addr  = 16'($urandom);
        chk("busy_after_start", busy == 1'b1, busy, 1);
        if (glitch) begin
            repeat (20) @(posedge clk_sys);
            #1 start = 1'b1;
            @(posedge clk_sys);
            #1 start = 1'b0;
        end
        cyc = 0;
        while (done_cnt == d0 && cyc < 20000) begin
            @(negedge clk_sys);
            cyc++;
        end
        chk("done_timeout", done_cnt != d0, cyc, 20000);
        repeat (3) @(negedge clk_sys);
        chk("done_pulses", done_cnt - d0 == 1, done_cnt - d0, 1);
        chk("stream_complete", exp_q.size() == 0, exp_q.size(), 0);
        chk("reads_complete", rd_q.size() == 0, rd_q.size(), 0);
        chk("rd_valid_overlap", ov_cnt == ov0, ov_cnt - ov0, 0);
        chk("idle_busy_done", {busy, done} == 2'b00, {busy, done}, 0);
    endtask

    initial begin
        int a0, cyc, s, l;
        for (int unsigned i = 0; i < 65536; i++) ram[i] = 8'($urandom);
        ram[16'h5200] = 8'hAA;
        ram[16'h5201] = 8'hBB;
        ram[16'h5202] = 8'hCC;
        repeat (3) @(negedge clk_sys);
        chk("reset_outputs", {mem_rd, out_valid, out_last, busy, done, out_data} == '0,
            {mem_rd, out_valid, out_last, busy, done, out_data}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk_sys);

        run_save(16'h5200, 16'h5202, 16'h5200, 1'b0);
        a0 = acc_cnt;
        run_save(16'h4000, 16'h41FF, 16'h4000, 1'b0);
        chk("byte_count_524", acc_cnt - a0 == 524, acc_cnt - a0, 524);
        run_save(16'hFFFE, 16'hFFFF, 16'h1234, 1'b0);
        run_save(16'h6000, 16'h5000, 16'h6000, 1'b0);

        stall_en = 1'b1;
        run_save(16'h5200, 16'h5202, 16'h5200, 1'b0);
        a0 = acc_cnt;
        run_save(16'h4000, 16'h41FF, 16'h4000, 1'b1);
        chk("byte_count_524_stall", acc_cnt - a0 == 524, acc_cnt - a0, 524);
        run_save(16'hFF00, 16'hFFFF, 16'hBEEF, 1'b0);
        for (int k = 0; k < 4; k++) begin
            s = int'($urandom_range(0, 65535));
            l = int'($urandom_range(0, 600));
            if (s + l > 65535) s = 65535 - l;
            run_save(s, s + l, int'($urandom_range(0, 65535)), 1'b0);
        end

        // Reset while a data byte is on the output, then a fresh save.
        stall_en = 1'b0;
        build(16'h5200, 16'h53FF, 16'h5200);
        a0 = acc_cnt;
        @(posedge clk_sys);
        #1;
        start = 1'b1;
        start_addr = 16'h5200;
        end_addr   = 16'h53FF;
        exec_addr  = 16'h5200;
        @(posedge clk_sys);
        #1 start = 1'b0;
        cyc = 0;
        while (!(acc_cnt - a0 >= 10 && out_valid && !mem_rd) && cyc < 2000) begin
            @(negedge clk_sys);
            cyc++;
        end
        chk("reset_window_timeout", cyc < 2000, cyc, 2000);
        #2 reset = 1'b1;
        #1;
        chk("mid_reset_outputs", {mem_rd, out_valid, out_last, busy, done, out_data} == '0,
            {mem_rd, out_valid, out_last, busy, done, out_data}, 0);
        exp_q.delete();
        rd_q.delete();
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("post_reset_idle", {out_valid, mem_rd, busy} == 3'b000, {out_valid, mem_rd, busy}, 0);
        run_save(16'h5200, 16'h5202, 16'h5200, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/cmd_saver.md
CMD_SAVER -- requirements
Module: cmd_saver

Interface
REQ-001 Parameter BLOCK_MAX, default 256, maximum data bytes per load record; legal range 1..256.
REQ-002 clk_sys  in  1  system clock (42 MHz); single clock domain.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  one-cycle pulse; begins a save; sampled only in IDLE.
REQ-005 start_addr  in  16  first RAM address to save, inclusive.
REQ-006 end_addr  in  16  last RAM address to save, inclusive.
REQ-007 exec_addr  in  16  entry address placed in the transfer record.
REQ-008 mem_rd  out  1  RAM read request; held until mem_ack.
REQ-009 mem_addr  out  16  RAM read address; stable while mem_rd=1.
REQ-010 mem_ack  in  1  one-cycle pulse; mem_data is valid in the same cycle.
REQ-011 mem_data  in  8  RAM read data.
REQ-012 out_data  out  8  /CMD byte stream.
REQ-013 out_valid  out  1  out_data is valid.
REQ-014 out_ready  in  1  consumer accepts the byte when out_valid&out_ready.
REQ-015 out_last  out  1  marks the final byte of the file; qualified by out_valid.
REQ-016 busy  out  1  high from the cycle after start until done.
REQ-017 done  out  1  one-cycle pulse after the last byte is accepted.

Function
REQ-018 States: IDLE, REC_TYPE, REC_LEN, REC_ALO, REC_AHI, MEM_REQ, DATA, XFR_TYPE, XFR_LEN, XFR_ALO, XFR_AHI, FIN.
REQ-019 IDLE+start latches all three addresses; goes to REC_TYPE if end_addr>=start_addr, else to XFR_TYPE (transfer record only).
REQ-020 Remaining count: 17-bit value = end_addr - cur + 1; the block length is n = min(BLOCK_MAX, remaining).
REQ-021 Load record bytes: 0x01, L=(n+2) mod 256, cur[7:0], cur[15:8], then n data bytes (so n=256 gives L=0x02 and n=254 gives L=0x00).
REQ-022 Each header/transfer state presents its byte with out_valid=1 and advances only on out_valid&out_ready; out_data stays stable while stalled.
REQ-023 MEM_REQ asserts mem_rd with mem_addr=cur; on mem_ack it captures mem_data into a holding register, drops mem_rd, and enters DATA.
REQ-024 DATA presents the captured byte; on acceptance cur increments and the block count decrements. At block count 0 it goes to REC_TYPE if remaining>0, else XFR_TYPE; otherwise it returns to MEM_REQ.
REQ-025 At most one outstanding read; mem_rd is never asserted while out_valid=1.
REQ-026 Transfer record: 0x02, 0x02, exec[7:0], exec[15:8]; out_last=1 only on exec[15:8].
REQ-027 FIN pulses done for one cycle, clears busy, and returns to IDLE.
REQ-028 cur is a 17-bit counter, so end_addr=0xFFFF terminates correctly with no wrap to 0x0000.
REQ-029 start while not in IDLE is ignored; input addresses are not re-sampled mid-save.
REQ-030 Throughput without stalls: every header byte takes 1 cycle; every data byte takes 1 cycle plus the mem_ack latency.

Reset
REQ-031 Reset returns the block to IDLE and clears mem_rd, out_valid, out_last, busy, done and out_data (0x00) immediately, including mid-record; no partial record resumes afterwards.
REQ-032 A mem_ack arriving after reset is ignored.

Structure
REQ-033 A shared package cmd_pkg holds the state enum and the constants CMD_LOAD=8'h01, CMD_XFER=8'h02 and XFER_LEN=8'h02, shared with cmd_loader.
REQ-034 Single module; no sub-module required.

Verification
REQ-035 start=0x5200, end=0x5202, exec=0x5200, RAM=AA BB CC, out_ready=1 -> stream 01 05 00 52 AA BB CC 02 02 00 52; out_last on the final byte; one done pulse.
REQ-036 start=0x4000, end=0x41FF -> two records 01 02 00 40 (256 bytes) and 01 02 00 41 (256 bytes), then 02 02 lo hi; 524 bytes total.
REQ-037 start=0xFFFE, end=0xFFFF -> 01 04 FE FF d0 d1 then transfer record; no read at 0x0000.
REQ-038 end<start (0x6000/0x5000), exec=0x6000 -> only 02 02 00 60; done pulse.
REQ-039 Random out_ready stalls with mem_ack latency 0-5 -> byte stream identical to the no-stall run; mem_rd never overlaps out_valid.
REQ-040 Reset asserted mid data byte -> all outputs 0 next edge; a fresh start yields a complete, correct stream.
